// File: rtl/pll_lock_sequencer.sv
// PLL bring-up and supervision: pulses PLL reset, waits for lock with timeout and retries,
// qualifies lock for a stable interval, then releases the downstream system reset.
//
// state         | meaning
// --------------+---------------------------------------------------------
// ST_ASSERT_RST | pll_reset_o high for RST_CYCLES cycles
// ST_WAIT_LOCK  | waiting for synchronized lock, LOCK_TIMEOUT cycle budget
// ST_STABLE     | lock seen, must stay high for LOCK_STABLE cycles
// ST_RUN        | lock qualified, downstream reset released
// ST_FAULT      | retries exhausted, PLL held in reset until restart/reset
module pll_lock_sequencer #(
  parameter int RST_CYCLES   = 27,
  parameter int LOCK_TIMEOUT = 27000,
  parameter int LOCK_STABLE  = 1024,
  parameter int MAX_RETRIES  = 3,
  parameter int CNT_W        = 16
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       pll_lock_i,
  input  logic       restart_i,
  output logic       pll_reset_o,
  output logic       sys_rst_o,
  output logic       ready_o,
  output logic       fault_o,
  output logic [3:0] retry_cnt_o
);

  typedef enum logic [2:0] {
    ST_ASSERT_RST,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN,
    ST_FAULT
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       retry;
  logic             lock_m;
  logic             lock_s;
  logic [3:0]       outs;

  // Output vector {pll_reset, sys_rst, ready, fault} registered alongside the next state.
  function automatic logic [3:0] decode(input state_t s);
    case (s)
      ST_ASSERT_RST: decode = 4'b1100;
      ST_WAIT_LOCK:  decode = 4'b0100;
      ST_STABLE:     decode = 4'b0100;
      ST_RUN:        decode = 4'b0010;
      ST_FAULT:      decode = 4'b1101;
      default:       decode = 4'b1100;
    endcase
  endfunction

  always_ff @(posedge clkin) begin
    if (reset) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
      state  <= ST_ASSERT_RST;
      outs   <= decode(ST_ASSERT_RST);
      cnt    <= '0;
      retry  <= '0;
    end else begin
      lock_m <= pll_lock_i;
      lock_s <= lock_m;
      if (restart_i) begin
        state <= ST_ASSERT_RST;
        outs  <= decode(ST_ASSERT_RST);
        cnt   <= '0;
        retry <= '0;
      end else begin
        case (state)
          ST_ASSERT_RST: begin
            if (cnt == RST_LAST) begin
              state <= ST_WAIT_LOCK;
              outs  <= decode(ST_WAIT_LOCK);
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_WAIT_LOCK: begin
            if (lock_s) begin
              state <= ST_STABLE;
              outs  <= decode(ST_STABLE);
              cnt   <= '0;
            end else if (cnt == TIMEOUT_LAST) begin
              cnt <= '0;
              if (retry == RETRY_MAX) begin
                state <= ST_FAULT;
                outs  <= decode(ST_FAULT);
              end else begin
                retry <= retry + 4'd1;
                state <= ST_ASSERT_RST;
                outs  <= decode(ST_ASSERT_RST);
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_STABLE: begin
            if (!lock_s) begin
              state <= ST_WAIT_LOCK;
              outs  <= decode(ST_WAIT_LOCK);
              cnt   <= '0;
            end else if (cnt == STABLE_LAST) begin
              state <= ST_RUN;
              outs  <= decode(ST_RUN);
              cnt   <= '0;
              retry <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_RUN: begin
            if (!lock_s) begin
              state <= ST_ASSERT_RST;
              outs  <= decode(ST_ASSERT_RST);
              cnt   <= '0;
              retry <= '0;
            end
          end
          ST_FAULT: begin
            cnt <= '0;
          end
          default: begin
            state <= ST_ASSERT_RST;
            outs  <= decode(ST_ASSERT_RST);
            cnt   <= '0;
            retry <= '0;
          end
        endcase
      end
    end
  end

  assign {pll_reset_o, sys_rst_o, ready_o, fault_o} = outs;
  assign retry_cnt_o = retry;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed bring-up/timeout/loss cases plus randomized lock,
// restart and reset traffic checked against a timestamp-based reference model.
module tb_pll_lock_sequencer;
  localparam int RST_C = 4;
  localparam int TO_C  = 20;
  localparam int ST_C  = 8;
  localparam int MR_C  = 2;

  localparam int P_PULSE  = 0;
  localparam int P_WAIT   = 1;
  localparam int P_STABLE = 2;
  localparam int P_RUN    = 3;
  localparam int P_FAULT  = 4;

  logic       clkin = 1'b0;
  logic       reset = 1'b1;
  logic       pll_lock_i = 1'b0;
  logic       restart_i = 1'b0;
  logic       pll_reset_o;
  logic       sys_rst_o;
  logic       ready_o;
  logic       fault_o;
  logic [3:0] retry_cnt_o;

  always #5 clkin = ~clkin;

  pll_lock_sequencer #(
    .RST_CYCLES  (RST_C),
    .LOCK_TIMEOUT(TO_C),
    .LOCK_STABLE (ST_C),
    .MAX_RETRIES (MR_C),
    .CNT_W       (16)
  ) dut (
    .clkin      (clkin),
    .reset      (reset),
    .pll_lock_i (pll_lock_i),
    .restart_i  (restart_i),
    .pll_reset_o(pll_reset_o),
    .sys_rst_o  (sys_rst_o),
    .ready_o    (ready_o),
    .fault_o    (fault_o),
    .retry_cnt_o(retry_cnt_o)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;
  int rst_edge = 0;
  int p_start = 0;
  int m_phase = P_PULSE;
  int m_fail = 0;
  int rel;
  bit lock_at [0:16383];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic enter(input int p);
    m_phase = p;
    p_start = edge_n;
  endtask

  // Reference: each phase remembers the edge it began on; lock_s at edge e is pll_lock_i
  // as sampled two edges earlier (zero if that sample predates the last reset).
  task automatic model_step();
    bit ls;
    int dur;
    if (reset) begin
      rst_edge = edge_n;
      enter(P_PULSE);
      m_fail = 0;
    end else begin
      ls  = (edge_n - 2 > rst_edge) ? lock_at[edge_n-2] : 1'b0;
      dur = edge_n - p_start;
      if (restart_i) begin
        enter(P_PULSE);
        m_fail = 0;
      end else begin
        case (m_phase)
          P_PULSE:  if (dur == RST_C) enter(P_WAIT);
          P_WAIT: begin
            if (ls) enter(P_STABLE);
            else if (dur == TO_C) begin
              if (m_fail == MR_C) enter(P_FAULT);
              else begin
                m_fail++;
                enter(P_PULSE);
              end
            end
          end
          P_STABLE: begin
            if (!ls) enter(P_WAIT);
            else if (dur == ST_C) begin
              enter(P_RUN);
              m_fail = 0;
            end
          end
          P_RUN: begin
            if (!ls) begin
              enter(P_PULSE);
              m_fail = 0;
            end
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic tick();
    @(posedge clkin);
    edge_n++;
    lock_at[edge_n] = pll_lock_i;
    model_step();
    #1;
    rel = edge_n - rst_edge;
    chk("pll_reset", {31'd0, pll_reset_o}, {31'd0, (m_phase == P_PULSE || m_phase == P_FAULT)});
    chk("sys_rst",   {31'd0, sys_rst_o},   {31'd0, (m_phase != P_RUN)});
    chk("ready",     {31'd0, ready_o},     {31'd0, (m_phase == P_RUN)});
    chk("fault",     {31'd0, fault_o},     {31'd0, (m_phase == P_FAULT)});
    chk("retry",     {28'd0, retry_cnt_o}, 32'(m_fail));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pll_lock_i = 1'b0;
    restart_i = 1'b0;
    tick();
    chk("reset_prst",  {31'd0, pll_reset_o}, 32'd1);
    chk("reset_sys",   {31'd0, sys_rst_o},   32'd1);
    chk("reset_ready", {31'd0, ready_o},     32'd0);
    chk("reset_fault", {31'd0, fault_o},     32'd0);
    chk("reset_retry", {28'd0, retry_cnt_o}, 32'd0);
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int len;
    bit lv;

    // Bring-up with lock first sampled at edge 7, then loss in RUN sampled at edge 25.
    do_reset();
    for (int k = 1; k <= 34; k++) begin
      pll_lock_i = (k >= 7 && k < 25);
      tick();
      if (k <= 20) begin
        chk("bringup_prst",  {31'd0, pll_reset_o}, {31'd0, (rel < 4)});
        chk("bringup_sys",   {31'd0, sys_rst_o},   {31'd0, (rel < 17)});
        chk("bringup_ready", {31'd0, ready_o},     {31'd0, (rel >= 17)});
      end else begin
        chk("loss_sys",  {31'd0, sys_rst_o},   {31'd0, (rel >= 27)});
        chk("loss_prst", {31'd0, pll_reset_o}, {31'd0, (rel >= 27 && rel < 31)});
        chk("loss_retry", {28'd0, retry_cnt_o}, 32'd0);
      end
    end

    // No lock at all: three attempts, then FAULT after edge 72.
    do_reset();
    for (int k = 1; k <= 80; k++) begin
      tick();
      chk("to_prst", {31'd0, pll_reset_o},
          {31'd0, (rel < 4) || (rel >= 24 && rel < 28) || (rel >= 48 && rel < 52) || (rel >= 72)});
      chk("to_fault", {31'd0, fault_o}, {31'd0, (rel >= 72)});
      chk("to_retry", {28'd0, retry_cnt_o}, (rel < 24) ? 32'd0 : (rel < 48) ? 32'd1 : 32'd2);
    end
    restart_i = 1'b1;
    tick();
    restart_i = 1'b0;
    chk("restart_fault", {31'd0, fault_o},     32'd0);
    chk("restart_prst",  {31'd0, pll_reset_o}, 32'd1);
    chk("restart_retry", {28'd0, retry_cnt_o}, 32'd0);

    // Random lock segments with occasional restart pulses and resets.
    do_reset();
    lv = 1'b0;
    for (int seg = 0; seg < 160; seg++) begin
      lv = ~lv;
      if ($urandom_range(0, 5) == 0) len = $urandom_range(60, 90);
      else len = $urandom_range(1, 40);
      for (int c = 0; c < len; c++) begin
        pll_lock_i = lv;
        restart_i  = ($urandom_range(0, 149) == 0);
        reset      = ($urandom_range(0, 399) == 0);
        tick();
      end
    end
    restart_i = 1'b0;
    reset = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
